// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver:
//   SEG_A..SEG_G     bit positions of each segment in a 7-bit pattern (bit0=a)
//   SEG_OFF          all segments dark (internal, active-high)
//   MAX_DIGITS       largest digit count the scanner supports
//   hex_to_seg()     nibble -> active-high a..g pattern
//   params_ok()      parameter legality test used at elaboration
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_OFF    = 7'h00;
   localparam int         MAX_DIGITS = 8;

   // Per-segment truth tables: bit h is 1 when hex digit h lights that segment.
   // Together they give 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
   //                    8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
   localparam logic [15:0] ON_A = 16'hD7ED;
   localparam logic [15:0] ON_B = 16'h279F;
   localparam logic [15:0] ON_C = 16'h2FFB;
   localparam logic [15:0] ON_D = 16'h7B6D;
   localparam logic [15:0] ON_E = 16'hFD45;
   localparam logic [15:0] ON_F = 16'hDF71;
   localparam logic [15:0] ON_G = 16'hEF7C;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      s        = SEG_OFF;
      s[SEG_A] = ON_A[nib];
      s[SEG_B] = ON_B[nib];
      s[SEG_C] = ON_C[nib];
      s[SEG_D] = ON_D[nib];
      s[SEG_E] = ON_E[nib];
      s[SEG_F] = ON_F[nib];
      s[SEG_G] = ON_G[nib];
      return s;
   endfunction

   function automatic bit params_ok(input int n_digits, input int clk_div,
                                    input int dead_cyc);
      return (n_digits >= 1) && (n_digits <= MAX_DIGITS) &&
             (clk_div >= 2) && (dead_cyc >= 0) && (dead_cyc < clk_div);
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the user-side display request and the board-side display pins.
//   i_value   4*N_DIGITS hex nibbles, nibble k -> digit k (digit 0 = LSD)
//   i_dp      decimal-point request per digit
//   i_blank   force digit dark
//   i_lzs     leading-zero suppression enable
//   i_load    capture the four fields above into the pending register
//   o_seg     segments a..g (bit0=a), pin polarity
//   o_dp      decimal-point segment, pin polarity
//   o_digits  digit enables, pin polarity
//   o_frame   one-cycle pulse when the scan wraps to digit 0
// master = user datapath / bench, slave = the driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] i_value;
   logic [N_DIGITS-1:0]   i_dp;
   logic [N_DIGITS-1:0]   i_blank;
   logic                  i_lzs;
   logic                  i_load;
   logic [6:0]            o_seg;
   logic                  o_dp;
   logic [N_DIGITS-1:0]   o_digits;
   logic                  o_frame;

   modport master (
      output i_value, i_dp, i_blank, i_lzs, i_load,
      input  o_seg, o_dp, o_digits, o_frame
   );

   modport slave (
      input  i_value, i_dp, i_blank, i_lzs, i_load,
      output o_seg, o_dp, o_digits, o_frame
   );
endinterface

// File: rtl/seg7_tick_gen.sv
// -----------------------------------------------------------------------------
// seg7_tick_gen
// Free-running prescaler counting 0..DIV-1; o_tick is high while the count is
// DIV-1, after which the count returns to 0.
//   i_clock    system clock (rising edge)
//   i_reset_n  asynchronous active-low reset, count -> 0
//   o_count    current prescaler count
//   o_tick     slot-boundary strobe
// -----------------------------------------------------------------------------
module seg7_tick_gen #(
   parameter  int DIV = 25000,
   localparam int CW  = $clog2(DIV)
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   output logic [CW-1:0] o_count,
   output logic          o_tick
);

   assign o_tick = (o_count == CW'(DIV - 1));

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_count <= '0;
      end else if (o_tick) begin
         o_count <= '0;
      end else begin
         o_count <= o_count + 1'b1;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed N-digit seven-segment driver. Each digit owns a slot of
// CLK_DIV cycles; the first DEAD_CYC cycles of every slot keep all digits off
// to avoid ghosting. New display data is taken through a pending register and
// only copied to the shadow register at a frame start, so a frame never shows
// a mix of old and new values.
//   i_clock    system clock (rising edge)
//   i_reset_n  asynchronous active-low reset; all pins go inactive at once
//   bus        seg7_scan_driver_if.slave (request inputs, display pins)
// -----------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS   = 4,
   parameter int CLK_DIV    = 25000,
   parameter int DEAD_CYC   = 2,
   parameter int ACTIVE_LOW = 1
) (
   input logic               i_clock,
   input logic               i_reset_n,
   seg7_scan_driver_if.slave bus
);

   localparam int              IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int              CW   = $clog2(CLK_DIV);
   localparam logic [IW-1:0]   LAST = IW'(N_DIGITS - 1);

   if (!params_ok(N_DIGITS, CLK_DIV, DEAD_CYC)) begin : g_bad_params
      $error("seg7_scan_driver: illegal N_DIGITS/CLK_DIV/DEAD_CYC");
   end

   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;
   logic                  tick;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_nxt;
   logic [IW-1:0]         slot_idx;
   logic                  frame_start;
   logic                  swap;
   logic                  scan_on;

   logic [4*N_DIGITS-1:0] pend_value, shad_value, src_value;
   logic [N_DIGITS-1:0]   pend_dp,    shad_dp,    src_dp;
   logic [N_DIGITS-1:0]   pend_blank, shad_blank, src_blank;
   logic                  pend_lzs,   shad_lzs,   src_lzs;
   logic                  pend_flag;

   logic [N_DIGITS-1:0]   dark;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt;
   logic [N_DIGITS-1:0]   digits_nxt;

   logic [6:0]            seg_p1;
   logic                  dp_p1;
   logic [N_DIGITS-1:0]   digits_p1;
   logic                  frame_p1;

   seg7_tick_gen #(.DIV(CLK_DIV)) u_tick (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .o_count   (count),
      .o_tick    (tick)
   );

   assign count_nxt   = tick ? '0 : count + 1'b1;
   assign idx_nxt     = (idx == LAST) ? '0 : idx + 1'b1;
   assign slot_idx    = tick ? idx_nxt : idx;
   assign frame_start = tick && (idx == LAST);
   assign swap        = frame_start && pend_flag;

   // The pattern latched on a frame-start tick must already use the data that
   // the shadow takes on that same edge, otherwise digit 0 would lag a frame.
   assign src_value = swap ? pend_value : shad_value;
   assign src_dp    = swap ? pend_dp    : shad_dp;
   assign src_blank = swap ? pend_blank : shad_blank;
   assign src_lzs   = swap ? pend_lzs   : shad_lzs;

   // Walk from the top digit down; a digit is suppressed while every nibble
   // from it upwards is zero. Digit 0 is never suppressed.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      dark       = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && (src_value[4*k +: 4] == 4'h0);
         dark[k]    = src_blank[k] || (src_lzs && zero_above && (k != 0));
      end
   end

   always_comb begin
      seg_nxt    = hex_to_seg(src_value[4*slot_idx +: 4]);
      dp_nxt     = src_dp[slot_idx];
      if (dark[slot_idx]) begin
         seg_nxt = SEG_OFF;
         dp_nxt  = 1'b0;
      end
      // Enables stay off until the first tick after reset, then follow the
      // dead-time window of each slot.
      digits_nxt = '0;
      if ((scan_on || tick) && (count_nxt >= CW'(DEAD_CYC))) begin
         digits_nxt[slot_idx] = 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         idx        <= LAST;
         scan_on    <= 1'b0;
         pend_flag  <= 1'b0;
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_lzs   <= 1'b0;
         shad_value <= '0;
         shad_dp    <= '0;
         shad_blank <= '0;
         shad_lzs   <= 1'b0;
      end else begin
         if (tick) begin
            idx     <= idx_nxt;
            scan_on <= 1'b1;
         end
         if (bus.i_load) begin
            pend_value <= bus.i_value;
            pend_dp    <= bus.i_dp;
            pend_blank <= bus.i_blank;
            pend_lzs   <= bus.i_lzs;
         end
         if (swap) begin
            shad_value <= pend_value;
            shad_dp    <= pend_dp;
            shad_blank <= pend_blank;
            shad_lzs   <= pend_lzs;
         end
         // A load on the swap edge refills pending, so the flag stays set.
         if (bus.i_load) begin
            pend_flag <= 1'b1;
         end else if (swap) begin
            pend_flag <= 1'b0;
         end
      end
   end

   // ---- output register stage (p1) ----
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         seg_p1    <= SEG_OFF;
         dp_p1     <= 1'b0;
         digits_p1 <= '0;
         frame_p1  <= 1'b0;
      end else begin
         digits_p1 <= digits_nxt;
         frame_p1  <= frame_start;
         if (tick) begin
            seg_p1 <= seg_nxt;
            dp_p1  <= dp_nxt;
         end
      end
   end

   assign bus.o_seg    = (ACTIVE_LOW != 0) ? ~seg_p1    : seg_p1;
   assign bus.o_dp     = (ACTIVE_LOW != 0) ? ~dp_p1     : dp_p1;
   assign bus.o_digits = (ACTIVE_LOW != 0) ? ~digits_p1 : digits_p1;
   assign bus.o_frame  = frame_p1;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised time-multiplexed driver for a multi-digit common-anode/cathode seven-segment display. It scans N digits from one clock, decodes hex nibbles and decimal points, and applies optional leading-zero suppression and anti-ghosting dead time. Values are updated tear-free at frame boundaries. It replaces the single-digit fixed-enable hookup used in the lab top levels, sitting between the user datapath and the board display pins.

## Interface
- N_DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_DIV, 25000: clock cycles per digit slot; must be ≥ 2.
- DEAD_CYC, 2: cycles at the start of each slot with all digits disabled; must be < CLK_DIV.
- ACTIVE_LOW, 1: when 1, o_seg, o_dp and o_digits are inverted at the pins.
- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_value  in  4*N_DIGITS  hex nibbles; nibble k drives digit k, with digit 0 least significant.
- i_dp  in  N_DIGITS  decimal-point request per digit.
- i_blank  in  N_DIGITS  force digit k dark.
- i_lzs  in  1  leading-zero suppression enable.
- i_load  in  1  capture i_value/i_dp/i_blank/i_lzs into the pending register.
- o_seg  out  7  segments, with bit0=a … bit6=g.
- o_dp  out  1  decimal-point segment.
- o_digits  out  N_DIGITS  digit enables.
- o_frame  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler counts 0..CLK_DIV-1. The tick is asserted when count = CLK_DIV-1, and the count then returns to 0.
- Index idx advances by 1 on each tick and wraps from N_DIGITS-1 to 0. The wrap is the frame start: o_frame=1 for that cycle.
- Load path:
  - i_load=1 writes the pending register and sets pend_flag.
  - At a frame-start tick with pend_flag=1, the shadow register is loaded from pending and pend_flag is cleared.
  - If i_load coincides with a frame-start tick, the shadow takes the old pending value. The new data goes to pending and pend_flag stays 1.
- Display is driven only from the shadow register, never directly from the inputs.
- Leading-zero suppression (shadow lzs=1): digit k is dark if all nibbles k..N_DIGITS-1 are 0 and k≠0. Digit 0 always shows its value.
- Dark digit (blank or suppressed): segments and dp all off.
- Decode table: 0-F with standard a-g patterns (internal active-high: 0=3F, 1=06, 2=5B, 5=6D, A=77, F=71).
- Outputs are registered and internally active-high; the ACTIVE_LOW inversion is applied after the output register.

## Timing
- Reset (async, immediate, including mid-scan):
  - prescaler=0, idx=N_DIGITS-1, shadow=0, pending=0, pend_flag=0.
  - o_seg=off, o_dp=off, o_digits all disabled, o_frame=0. "Off/disabled" means all 1s when ACTIVE_LOW=1.
- First tick after reset release occurs CLK_DIV cycles later. On that tick idx→0, o_frame pulses, and the shadow loads if pend_flag=1.
- o_seg/o_dp change on the tick edge to the new idx's pattern.
- o_digits is all disabled from the tick edge for DEAD_CYC cycles. It then enables only digit idx for CLK_DIV-DEAD_CYC cycles.
- Frame period = N_DIGITS*CLK_DIV cycles.
- i_load → visible latency: at most one frame plus one slot.
- N_DIGITS=1: idx stays 0, and every tick is a frame start.

## Structure
- Package seg7_pkg holds:
  - segment bit-index constants;
  - SEG_OFF;
  - function hex_to_seg(logic [3:0]) returning logic [6:0], active-high;
  - parameter-legality check macros/asserts.
- Sub-module seg7_tick_gen (parameter DIV) provides the prescaler and tick output with the same clock/reset.
- The top holds idx, the pending/shadow registers, LZS logic and the output registers.

## Test plan
- Reset with N_DIGITS=4, CLK_DIV=8, DEAD_CYC=2, ACTIVE_LOW=1 -> o_digits=4'hF, o_seg=7'h7F, o_dp=1. At cycle 8 o_frame=1, and at cycle 10 o_digits=4'hE.
- i_load with i_value=16'h12A0, i_dp=4'b0100 -> from the next frame, digits 0..3 show o_seg=40, 08, 24, 79. o_dp=0 only in slot 2. Each enable lasts 6 cycles.
- i_lzs=1, i_value=16'h0050 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40. With i_value=0, only digit 0 shows 40.
- i_load pulsed mid-frame, then again on the frame-start tick -> the first value appears at that frame. The second appears exactly one frame later, and no mixed-value frame is observed.
- i_reset_n asserted mid-slot with a digit enabled -> all outputs go inactive in the same cycle, without waiting for a clock edge. The shadow is cleared, and after release the scan restarts at digit 0 after 8 cycles.
- i_blank=4'b0010 with i_value=16'hFFFF -> slot 1 shows 7F with o_dp=1, and the other slots show 0E (F, inverted).
